dff_checker: RTL

Synthesizable self-checking monitor that sits on the far side of the `dff` DUT interface. It observes the stimulus driven into the DUT and the DUT response, rebuilds the expected response through an internal delay line, and compares the two every cycle. It keeps saturating pass and fail counters and a sticky error flag, so a DFF instance can be checked on silicon or in emulation without the class-based environment.

---
 rtl/dff_chk_pkg.sv | 21 ++
 rtl/dff_chk_delay.sv | 43 ++++
 rtl/dff_checker.sv | 118 +++++++++++
 3 files changed

// File: rtl/dff_chk_pkg.sv
// dff_chk_pkg -- shared types for the dff_checker slice.
// Rev 1.0
`default_nettype none
package dff_chk_pkg;

  localparam int LAT_MAX     = 4;
  localparam int DATA_W_DFLT = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CHECK = 2'd2
  } chk_state_e;

  typedef struct packed {
    logic                   valid;
    logic [DATA_W_DFLT-1:0] data;
  } stage_t;

endpackage
`default_nettype wire

// File: rtl/dff_chk_delay.sv
// dff_chk_delay -- LAT-stage valid/data shift register with synchronous flush.
// Rev 1.0
`default_nettype none
module dff_chk_delay #(
  parameter int DATA_W = 1,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              tail_valid,
  output logic [DATA_W-1:0] tail_data,
  output logic              any_valid
);

  logic [LAT-1:0]             valid_q;
  logic [LAT-1:0][DATA_W-1:0] data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      data_q  <= '0;
    end else if (flush) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q[0] <= in_valid;
      data_q[0]  <= in_data;
      for (int i = 1; i < LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign tail_valid = valid_q[LAT-1];
  assign tail_data  = data_q[LAT-1];
  assign any_valid  = |valid_q;

endmodule
`default_nettype wire

// File: rtl/dff_checker.sv
// dff_checker -- passive DFF checker: delay-line reference, saturating pass/fail counters, sticky err.
// Rev 1.0; define DFF_CHK_FIRST_FAIL_EN to build the first-failure capture registers.
`default_nettype none
module dff_checker
  import dff_chk_pkg::*;
#(
  parameter int DATA_W = 1,
  parameter int LAT    = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [DATA_W-1:0] stim,
  input  logic [DATA_W-1:0] resp,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              err,
  output logic              busy,
  output logic [DATA_W-1:0] ff_exp,
  output logic [DATA_W-1:0] ff_got,
  output logic [CNT_W-1:0]  ff_idx
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  chk_state_e        state, state_nxt;
  logic              tail_valid;
  logic              any_valid;
  logic [DATA_W-1:0] tail_data;
  logic              hit;
  logic              miss;

  dff_chk_delay #(
    .DATA_W (DATA_W),
    .LAT    (LAT)
  ) u_delay (
    .clk        (clk),
    .rst        (rst),
    .flush      (clr),
    .in_valid   (en),
    .in_data    (stim),
    .tail_valid (tail_valid),
    .tail_data  (tail_data),
    .any_valid  (any_valid)
  );

  assign hit  = tail_valid && (resp == tail_data);
  assign miss = tail_valid && (resp != tail_data);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (en) state_nxt = FILL;
      FILL:    if (tail_valid) state_nxt = CHECK;
      CHECK:   if (!en && !any_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  assign busy = (state != IDLE);

  // clr wins over a same-cycle compare: the compare result is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      err      <= 1'b0;
    end else if (clr) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (hit && pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + 1'b1;
      if (miss && fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
      if (miss) err <= 1'b1;
    end
  end

`ifdef DFF_CHK_FIRST_FAIL_EN
  logic [CNT_W-1:0] sample_idx;

  // err still low on a miss means this is the first failure since reset/clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_idx <= '0;
      ff_exp     <= '0;
      ff_got     <= '0;
      ff_idx     <= '0;
    end else if (clr) begin
      sample_idx <= '0;
      ff_exp     <= '0;
      ff_got     <= '0;
      ff_idx     <= '0;
    end else begin
      if (tail_valid && sample_idx != CNT_MAX) sample_idx <= sample_idx + 1'b1;
      if (miss && !err) begin
        ff_exp <= tail_data;
        ff_got <= resp;
        ff_idx <= sample_idx;
      end
    end
  end
`else
  assign ff_exp = '0;
  assign ff_got = '0;
  assign ff_idx = '0;
`endif

endmodule
`default_nettype wire
